// File: rtl/cprs_sched_pkg.sv
// ---------------------------------------------------------------------------
// cprs_sched_pkg
// Shared types and defaults for the compressor packet scheduler.
//   sched_state_t : scheduler FSM states (idle / transfer / guard gap)
//   rbg_idx_t     : RBG index within a packet (up to 16 RBGs)
//   smp_cnt_t     : sample counter, wide enough for PKT_LEN up to 4095
// ---------------------------------------------------------------------------
package cprs_sched_pkg;

  localparam int NREQ        = 2;
  localparam int DEF_IW      = 40;
  localparam int DEF_PKT_LEN = 1584;
  localparam int DEF_RBG_LEN = 132;
  localparam int DEF_GAP     = 8;

  localparam int CNT_W = 12;
  localparam int GAP_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } sched_state_t;

  typedef logic [3:0]       rbg_idx_t;
  typedef logic [CNT_W-1:0] smp_cnt_t;

endpackage

// File: rtl/cprs_rr_arb2.sv
// ---------------------------------------------------------------------------
// cprs_rr_arb2
// Two-way arbiter. A lone requester always wins. On a tie the source not
// granted last wins; the last-granted pointer resets to 1 so source 0 wins
// the first tie.
// Build option: CPRS_SCHED_FIXED_PRIO_EN -> fixed priority, source 0 wins a
// tie and no pointer exists.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   req       : request vector
//   gnt_en    : grant is taken this cycle when a request is present
//   gnt_vld   : at least one request present
//   gnt_idx   : index of the winning source
// ---------------------------------------------------------------------------
module cprs_rr_arb2
  import cprs_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            gnt_en,
  output logic            gnt_vld,
  output logic            gnt_idx
);

`ifdef CPRS_SCHED_FIXED_PRIO_EN

  logic unused_arb;
  assign unused_arb = ^{clk, rst, gnt_en};

  always_comb begin
    gnt_vld = |req;
    gnt_idx = ~req[0];
  end

`else

  logic last_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (gnt_en && gnt_vld) begin
      last_gnt <= gnt_idx;
    end
  end

  always_comb begin
    gnt_vld = |req;
    if (req == 2'b11) begin
      gnt_idx = ~last_gnt;
    end else begin
      gnt_idx = req[1];
    end
  end

`endif

endmodule

// File: rtl/cprs_pkt_sched.sv
// ---------------------------------------------------------------------------
// cprs_pkt_sched
// Packet scheduler in front of the per-symbol compressor. Arbitrates between
// two FWFT cell buffers, streams the winner's whole packet with sop/eop/vld
// framing and RBG load strobes, then forces GAP idle cycles.
// Build option: CPRS_SCHED_FIXED_PRIO_EN (handled in cprs_rr_arb2).
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   i_req                 : per-source complete-packet request
//   o_rd                  : per-source read strobe (FWFT, consumed same cycle)
//   i_din_re / i_din_im   : per-source 16-channel samples
//   i_beam_pwr            : per-source beam power (valid on RBG last sample)
//   i_info_0 / i_info_1   : per-source packet header
//   o_sel                 : granted source
//   o_sop / o_eop / o_vld : packet framing
//   o_dout_re / o_dout_im : muxed samples (hold when o_vld=0)
//   o_rbg_load / o_rbg_idx: RBG last-sample strobe and RBG index
//   o_beam_pwr            : beam power, qualified by o_rbg_load
//   o_info_0 / o_info_1   : header of the current packet
//   o_busy                : high while transferring or in the guard gap
// ---------------------------------------------------------------------------
module cprs_pkt_sched
  import cprs_sched_pkg::*;
#(
  parameter int IW      = DEF_IW,
  parameter int PKT_LEN = DEF_PKT_LEN,
  parameter int RBG_LEN = DEF_RBG_LEN,
  parameter int GAP     = DEF_GAP
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NREQ-1:0]                 i_req,
  output logic [NREQ-1:0]                 o_rd,
  input  logic [NREQ-1:0][15:0][IW-1:0]   i_din_re,
  input  logic [NREQ-1:0][15:0][IW-1:0]   i_din_im,
  input  logic [NREQ-1:0][15:0][31:0]     i_beam_pwr,
  input  logic [NREQ-1:0][63:0]           i_info_0,
  input  logic [NREQ-1:0][63:0]           i_info_1,
  output logic                            o_sel,
  output logic                            o_sop,
  output logic                            o_eop,
  output logic                            o_vld,
  output logic [15:0][IW-1:0]             o_dout_re,
  output logic [15:0][IW-1:0]             o_dout_im,
  output logic                            o_rbg_load,
  output rbg_idx_t                        o_rbg_idx,
  output logic [15:0][31:0]               o_beam_pwr,
  output logic [63:0]                     o_info_0,
  output logic [63:0]                     o_info_1,
  output logic                            o_busy
);

  sched_state_t     state;
  sched_state_t     state_nxt;
  smp_cnt_t         smp_cnt;
  smp_cnt_t         rbg_cnt;
  rbg_idx_t         rbg_idx;
  logic [GAP_W-1:0] gap_cnt;
  logic             gnt_idx;
  logic             arb_vld;
  logic             arb_idx;
  logic             grant;
  logic             xfer;
  logic             smp_last;
  logic             rbg_last;
  logic             gap_last;

  assign xfer     = (state == ST_XFER);
  assign smp_last = (smp_cnt == CNT_W'(PKT_LEN - 1));
  assign rbg_last = (rbg_cnt == CNT_W'(RBG_LEN - 1));
  assign gap_last = (gap_cnt == GAP_W'(GAP - 1));

  // i_req is only looked at while idle; the arbiter pointer moves only then.
  cprs_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (i_req),
    .gnt_en  (state == ST_IDLE),
    .gnt_vld (arb_vld),
    .gnt_idx (arb_idx)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (arb_vld)  state_nxt = ST_XFER;
      ST_XFER: if (smp_last) state_nxt = ST_GAP;
      ST_GAP:  if (gap_last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs. o_rd is decoded straight from state so reset drops it at once.
  always_comb begin
    grant  = 1'b0;
    o_rd   = '0;
    o_busy = 1'b0;
    case (state)
      ST_IDLE: grant = arb_vld;
      ST_XFER: begin
        o_rd[gnt_idx] = 1'b1;
        o_busy        = 1'b1;
      end
      ST_GAP:  o_busy = 1'b1;
      default: ;
    endcase
  end

  // Grant latch and packet header capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_idx  <= 1'b0;
      o_info_0 <= '0;
      o_info_1 <= '0;
    end else if (grant) begin
      gnt_idx  <= arb_idx;
      o_info_0 <= i_info_0[arb_idx];
      o_info_1 <= i_info_1[arb_idx];
    end
  end

  // Sample / RBG counters. rbg_idx tracks count/RBG_LEN by stepping on each
  // RBG boundary instead of dividing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_cnt <= '0;
      rbg_cnt <= '0;
      rbg_idx <= '0;
    end else if (xfer && !smp_last) begin
      smp_cnt <= smp_cnt + 1'b1;
      if (rbg_last) begin
        rbg_cnt <= '0;
        rbg_idx <= rbg_idx + 1'b1;
      end else begin
        rbg_cnt <= rbg_cnt + 1'b1;
      end
    end else begin
      smp_cnt <= '0;
      rbg_cnt <= '0;
      rbg_idx <= '0;
    end
  end

  // Guard gap counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (state == ST_GAP) begin
      gap_cnt <= gap_cnt + 1'b1;
    end else begin
      gap_cnt <= '0;
    end
  end

  // Output register stage: everything reflects the cycle in which o_rd was high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_vld      <= 1'b0;
      o_sop      <= 1'b0;
      o_eop      <= 1'b0;
      o_rbg_load <= 1'b0;
      o_rbg_idx  <= '0;
      o_sel      <= 1'b0;
      o_dout_re  <= '0;
      o_dout_im  <= '0;
      o_beam_pwr <= '0;
    end else begin
      o_vld      <= xfer;
      o_sop      <= xfer && (smp_cnt == '0);
      o_eop      <= xfer && smp_last;
      o_rbg_load <= xfer && rbg_last;
      o_rbg_idx  <= rbg_idx;
      o_sel      <= gnt_idx;
      if (xfer) begin
        o_dout_re  <= i_din_re[gnt_idx];
        o_dout_im  <= i_din_im[gnt_idx];
        o_beam_pwr <= i_beam_pwr[gnt_idx];
      end
    end
  end

endmodule

// File: tb/tb_cprs_pkt_sched.sv
module tb_cprs_pkt_sched;
  import cprs_sched_pkg::*;

  localparam int IW      = 40;
  localparam int PKT_LEN = 1584;
  localparam int RBG_LEN = 132;
  localparam int GAP     = 8;

  logic                       clk;
  logic                       rst;
  logic [1:0]                 i_req;
  logic [1:0]                 o_rd;
  logic [1:0][15:0][IW-1:0]   i_din_re;
  logic [1:0][15:0][IW-1:0]   i_din_im;
  logic [1:0][15:0][31:0]     i_beam_pwr;
  logic [1:0][63:0]           i_info_0;
  logic [1:0][63:0]           i_info_1;
  logic                       o_sel;
  logic                       o_sop;
  logic                       o_eop;
  logic                       o_vld;
  logic [15:0][IW-1:0]        o_dout_re;
  logic [15:0][IW-1:0]        o_dout_im;
  logic                       o_rbg_load;
  logic [3:0]                 o_rbg_idx;
  logic [15:0][31:0]          o_beam_pwr;
  logic [63:0]                o_info_0;
  logic [63:0]                o_info_1;
  logic                       o_busy;

  cprs_pkt_sched #(
    .IW      (IW),
    .PKT_LEN (PKT_LEN),
    .RBG_LEN (RBG_LEN),
    .GAP     (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .o_rd       (o_rd),
    .i_din_re   (i_din_re),
    .i_din_im   (i_din_im),
    .i_beam_pwr (i_beam_pwr),
    .i_info_0   (i_info_0),
    .i_info_1   (i_info_1),
    .o_sel      (o_sel),
    .o_sop      (o_sop),
    .o_eop      (o_eop),
    .o_vld      (o_vld),
    .o_dout_re  (o_dout_re),
    .o_dout_im  (o_dout_im),
    .o_rbg_load (o_rbg_load),
    .o_rbg_idx  (o_rbg_idx),
    .o_beam_pwr (o_beam_pwr),
    .o_info_0   (o_info_0),
    .o_info_1   (o_info_1),
    .o_busy     (o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk_int(input string name, input longint act, input longint exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_wide(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- source model (FWFT buffers) ----------------
  int k   [2] = '{0, 0};
  int pkt [2] = '{0, 0};
  int npk [2] = '{0, 0};

  function automatic logic [15:0][IW-1:0] smp_re(input int s, input int p, input int kk);
    logic [15:0][IW-1:0] r;
    for (int ch = 0; ch < 16; ch++) r[ch] = {8'(s + 1), 8'(p), 8'(ch), 16'(kk)};
    return r;
  endfunction

  function automatic logic [15:0][IW-1:0] smp_im(input int s, input int p, input int kk);
    logic [15:0][IW-1:0] r;
    for (int ch = 0; ch < 16; ch++) r[ch] = {8'(p), 8'(s + 8'h70), 8'(ch + 16), 16'(kk ^ 16'h5a5a)};
    return r;
  endfunction

  function automatic logic [15:0][31:0] beam(input int s, input int p, input int kk);
    logic [15:0][31:0] r;
    for (int ch = 0; ch < 16; ch++) r[ch] = {4'(s + 4), 8'(p), 4'(ch), 16'(kk * 3)};
    return r;
  endfunction

  function automatic logic [63:0] info0(input int s, input int p);
    return {32'hC0DE_0000 | 32'(s), 32'(p)};
  endfunction

  function automatic logic [63:0] info1(input int s, input int p);
    return {32'hBEEF_0000 | 32'(s), 32'(p * 7 + 1)};
  endfunction

  task automatic drive();
    for (int s = 0; s < 2; s++) begin
      i_req[s]      = (npk[s] != 0);
      i_din_re[s]   = smp_re(s, pkt[s], k[s]);
      i_din_im[s]   = smp_im(s, pkt[s], k[s]);
      i_beam_pwr[s] = beam(s, pkt[s], k[s]);
      i_info_0[s]   = info0(s, pkt[s]);
      i_info_1[s]   = info1(s, pkt[s]);
    end
  endtask

  initial begin : src_model
    logic [1:0] rdq;
    forever begin
      @(negedge clk);
      rdq = o_rd;
      @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
        if (rdq[s]) begin
          k[s]++;
          if (k[s] == PKT_LEN) begin
            k[s] = 0;
            pkt[s]++;
            if (npk[s] > 0) npk[s]--;
          end
        end
      end
      drive();
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int src;
    int pkt;
    int exp_sop_cyc;  // -1: not checked
    int exp_gap;      // idle cycles since previous eop, -1: not checked
  } desc_t;

  desc_t exp_q[$];
  int    done_pkts = 0;

  initial begin : monitor
    desc_t               cur;
    int                  idx;
    int                  nrbg;
    int                  idle_cnt;
    bit                  in_pkt;
    bit                  prev_vld;
    logic [15:0][IW-1:0] last_re;
    in_pkt   = 0;
    prev_vld = 0;
    idle_cnt = -1;
    idx      = 0;
    nrbg     = 0;
    last_re  = '0;
    cur      = '{0, 0, -1, -1};
    forever begin
      @(negedge clk);
      if (rst) begin
        in_pkt   = 0;
        prev_vld = 0;
        idle_cnt = -1;
      end else begin
        if (o_vld) begin
          if (o_sop) begin
            chk_int("sop_outside_pkt", int'(in_pkt), 0);
            chk_int("sop_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              cur    = exp_q.pop_front();
              in_pkt = 1;
              idx    = 0;
              nrbg   = 0;
              if (cur.exp_sop_cyc >= 0) chk_int("sop_cycle", cyc, cur.exp_sop_cyc);
              if (cur.exp_gap >= 0)     chk_int("eop_to_sop_idle", idle_cnt, cur.exp_gap);
            end
          end
          if (in_pkt) begin
            last_re = smp_re(cur.src, cur.pkt, idx);
            chk_wide("dout_re", o_dout_re, last_re);
            chk_wide("dout_im", o_dout_im, smp_im(cur.src, cur.pkt, idx));
            chk_int("sel", o_sel, cur.src);
            chk_int("info_0", o_info_0, info0(cur.src, cur.pkt));
            chk_int("info_1", o_info_1, info1(cur.src, cur.pkt));
            chk_int("busy_in_pkt", o_busy, 1);
            chk_int("sop", o_sop, idx == 0);
            chk_int("eop", o_eop, idx == PKT_LEN - 1);
            chk_int("rbg_load", o_rbg_load, (idx % RBG_LEN) == RBG_LEN - 1);
            chk_int("rbg_idx", o_rbg_idx, idx / RBG_LEN);
            if (o_rbg_load) begin
              chk_wide("beam_pwr", o_beam_pwr, beam(cur.src, cur.pkt, idx));
              nrbg++;
            end
            if (idx == PKT_LEN - 1) begin
              chk_int("rbg_pulses", nrbg, PKT_LEN / RBG_LEN);
              in_pkt   = 0;
              idle_cnt = 0;
              done_pkts++;
            end
            idx++;
          end else if (!o_sop) begin
            chk_int("vld_framed", int'(in_pkt), 1);
          end
        end else begin
          if (in_pkt) chk_int("vld_in_pkt", o_vld, 1);
          if (prev_vld) chk_wide("dout_hold", o_dout_re, last_re);
          if (idle_cnt >= 0) idle_cnt++;
        end
        prev_vld = o_vld;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(input int n, input int limit);
    int c = 0;
    while (done_pkts < n && c < limit) begin
      @(negedge clk);
      c++;
    end
    chk_int("pkts_done", done_pkts, n);
    c = 0;
    while (o_busy && c < 64) begin
      @(negedge clk);
      c++;
    end
    chk_int("idle_after", o_busy, 0);
    @(posedge clk);
    #2;
  endtask

  task automatic wait_k0(input int target);
    int c = 0;
    while (k[0] != target && c < 3000) begin
      @(posedge clk);
      #2;
      c++;
    end
    chk_int("k0_reached", k[0], target);
  endtask

  initial begin : stim
    int nb;
    int nr0;
    int nr1;
    rst   = 1'b1;
    i_req = '0;
    drive();
    repeat (3) @(posedge clk);
    #2;
    chk_int("rst_rd", o_rd, 0);
    chk_int("rst_vld", o_vld, 0);
    chk_int("rst_busy", o_busy, 0);
    chk_int("rst_sel", o_sel, 0);
    chk_int("rst_rbg_idx", o_rbg_idx, 0);
    chk_int("rst_info_0", o_info_0, 0);
    chk_wide("rst_dout", o_dout_re, '0);
    rst = 1'b0;

    // Single request from source 0
    while (cyc < 9) @(posedge clk);
    #2;
    npk[0] = 1;
    drive();
    exp_q.push_back('{0, pkt[0], cyc + 2, -1});
    nb = 0; nr0 = 0; nr1 = 0;
    repeat (1700) begin
      @(negedge clk);
      if (o_busy)  nb++;
      if (o_rd[0]) nr0++;
      if (o_rd[1]) nr1++;
    end
    chk_int("busy_cycles", nb, PKT_LEN + GAP);
    chk_int("rd0_cycles", nr0, PKT_LEN);
    chk_int("rd1_cycles", nr1, 0);
    wait_done(1, 500);

    // Late request: source 1 rises mid-packet of source 0
    npk[0] = 1;
    drive();
    exp_q.push_back('{0, pkt[0], -1, -1});
    wait_k0(500);
    npk[1] = 1;
    drive();
    exp_q.push_back('{1, pkt[1], -1, GAP + 1});
    @(negedge clk);
    chk_int("late_req_ignored", o_rd, 1);
    wait_done(3, 4000);

    // Tie held: round robin 0,1,0,1 back to back
    npk[0] = 2;
    npk[1] = 2;
    drive();
    exp_q.push_back('{0, pkt[0],     -1, -1});
    exp_q.push_back('{1, pkt[1],     -1, GAP + 1});
    exp_q.push_back('{0, pkt[0] + 1, -1, GAP + 1});
    exp_q.push_back('{1, pkt[1] + 1, -1, GAP + 1});
    wait_done(7, 8000);

    // Reset in the middle of a source 0 packet
    npk[0] = 1;
    drive();
    exp_q.push_back('{0, pkt[0], -1, -1});
    wait_k0(700);
    rst = 1'b1;
    #1;
    chk_int("midrst_rd", o_rd, 0);
    chk_int("midrst_vld", o_vld, 0);
    chk_int("midrst_eop", o_eop, 0);
    chk_int("midrst_busy", o_busy, 0);
    chk_int("midrst_info_0", o_info_0, 0);
    chk_wide("midrst_dout", o_dout_re, '0);
    npk[0] = 0;
    k[0]   = 0;
    pkt[0]++;
    drive();
    repeat (2) @(posedge clk);
    #2;
    rst    = 1'b0;
    npk[1] = 1;
    drive();
    exp_q.push_back('{1, pkt[1], cyc + 2, -1});
    wait_done(8, 2000);

    chk_int("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
